// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types, constants and width helpers for the PC-redirect controller.
package redirect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SQUASH  = 2'd2
  } state_e;

  // Default source ordering: lower index wins arbitration.
  localparam int SRC_BRANCH = 0;
  localparam int SRC_JALR   = 1;
  localparam int SRC_JAL    = 2;

  // Two flush bits per source, source 0 in the LSBs:
  // branch flushes IF/ID+ID/EX, JALR and JAL flush IF/ID only.
  localparam logic [5:0] DEF_SRC_FLUSH_MASK = 6'b01_01_11;

  // Width of the source-index code, which must also hold NUM_SRC (the PC+4 code).
  function automatic int srcw(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

  // Width of the squash-window counter; at least one bit even for a zero window.
  function automatic int squash_cw(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module redirect_prio_enc #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Pick the first asserted request scanning upward from index 0.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < unsigned'(N); i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC-redirect and flush controller: fixed-priority arbitration of redirect
// sources, a pending slot that survives front-end stalls, and a squash window
// that drops wrong-path requests after each issued redirect. All outputs are
// registered.
module pc_redirect_ctrl
  import redirect_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_SRC       = 3,
  parameter int STAGES        = 2,
  parameter logic [NUM_SRC*STAGES-1:0] SRC_FLUSH_MASK = DEF_SRC_FLUSH_MASK,
  parameter int SQUASH_CYCLES = 1,
  localparam int SRCW = srcw(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NUM_SRC-1:0]      req,
  input  logic [NUM_SRC*XLEN-1:0] req_target,
  output logic                    pc_redirect,
  output logic [XLEN-1:0]         pc_target,
  output logic [SRCW-1:0]         pc_src,
  output logic [STAGES-1:0]       flush,
  output logic                    busy
);

  localparam int CW = squash_cw(SQUASH_CYCLES);
  localparam logic [SRCW-1:0] SRC_NONE = SRCW'(NUM_SRC);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SQUASH_CYCLES);

  if (NUM_SRC < 1 || STAGES < 1 || SQUASH_CYCLES < 0) begin : g_bad_params
    $error("pc_redirect_ctrl: illegal parameter set");
  end

  state_e            state_q, state_d;
  logic [SRCW-1:0]   pend_idx_q, pend_idx_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              redir_q, redir_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [SRCW-1:0]   src_q, src_d;
  logic [STAGES-1:0] flush_q, flush_d;

  logic              win_valid;
  logic [SRCW-1:0]   win_idx;
  logic [XLEN-1:0]   win_tgt;

  logic              issue;
  logic [SRCW-1:0]   iss_idx;
  logic [XLEN-1:0]   iss_tgt;
  logic              repl;

  redirect_prio_enc #(
    .N  (NUM_SRC),
    .IW (SRCW)
  ) u_prio (
    .req_i   (req),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  // Target slice of the fresh arbitration winner.
  always_comb begin
    win_tgt = req_target[int'(win_idx)*XLEN +: XLEN];
  end

  // Next-state, pending-slot, squash-counter and output-register logic.
  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    redir_d    = 1'b0;
    tgt_d      = tgt_q;
    src_d      = SRC_NONE;
    flush_d    = '0;
    issue      = 1'b0;
    iss_idx    = win_idx;
    iss_tgt    = win_tgt;
    repl       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          if (!stall) begin
            issue = 1'b1;
          end else begin
            pend_idx_d = win_idx;
            pend_tgt_d = win_tgt;
            state_d    = PENDING;
          end
        end
      end
      PENDING: begin
        // A higher-priority arrival replaces the slot before any issue, so
        // the replacement is what goes out when stall drops in that cycle.
        repl = win_valid && (win_idx < pend_idx_q);
        if (repl) begin
          pend_idx_d = win_idx;
          pend_tgt_d = win_tgt;
        end
        iss_idx = repl ? win_idx : pend_idx_q;
        iss_tgt = repl ? win_tgt : pend_tgt_q;
        if (!stall) begin
          issue = 1'b1;
        end
      end
      SQUASH: begin
        if (!stall) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (issue) begin
      redir_d = 1'b1;
      tgt_d   = iss_tgt;
      src_d   = iss_idx;
      flush_d = SRC_FLUSH_MASK[int'(iss_idx)*STAGES +: STAGES];
      cnt_d   = CNT_LOAD;
      state_d = (SQUASH_CYCLES == 0) ? IDLE : SQUASH;
    end
  end

  // State, pending slot, squash counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
      redir_q    <= 1'b0;
      tgt_q      <= '0;
      src_q      <= SRC_NONE;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
      redir_q    <= redir_d;
      tgt_q      <= tgt_d;
      src_q      <= src_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_redirect = redir_q;
  assign pc_target   = tgt_q;
  assign pc_src      = src_q;
  assign flush       = flush_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: three instances with squash windows of
// 0, 1 and 2 share the stimulus; each phase resets and checks one of them
// against expectations queued when the stimulus is driven.
module tb_pc_redirect_ctrl;

  typedef struct {
    logic        redir;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [1:0]  flush;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  req = '0;
  logic [95:0] tgt = '0;

  logic        redir_w [3];
  logic [31:0] tgt_w   [3];
  logic [1:0]  src_w   [3];
  logic [1:0]  flush_w [3];
  logic        busy_w  [3];

  exp_t sb[$];
  int   sel = 1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(32), .NUM_SRC(3), .STAGES(2), .SQUASH_CYCLES(0)) u_sc0 (
    .clk(clk), .reset(rst), .stall(stall), .req(req), .req_target(tgt),
    .pc_redirect(redir_w[0]), .pc_target(tgt_w[0]), .pc_src(src_w[0]),
    .flush(flush_w[0]), .busy(busy_w[0]));

  pc_redirect_ctrl #(.XLEN(32), .NUM_SRC(3), .STAGES(2), .SQUASH_CYCLES(1)) u_sc1 (
    .clk(clk), .reset(rst), .stall(stall), .req(req), .req_target(tgt),
    .pc_redirect(redir_w[1]), .pc_target(tgt_w[1]), .pc_src(src_w[1]),
    .flush(flush_w[1]), .busy(busy_w[1]));

  pc_redirect_ctrl #(.XLEN(32), .NUM_SRC(3), .STAGES(2), .SQUASH_CYCLES(2)) u_sc2 (
    .clk(clk), .reset(rst), .stall(stall), .req(req), .req_target(tgt),
    .pc_redirect(redir_w[2]), .pc_target(tgt_w[2]), .pc_src(src_w[2]),
    .flush(flush_w[2]), .busy(busy_w[2]));

  function automatic exp_t E(input logic rd, input logic [1:0] s, input logic [31:0] t,
                             input logic [1:0] f, input logic b);
    exp_t e;
    e.redir = rd; e.src = s; e.tgt = t; e.flush = f; e.busy = b;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s (sc=%0d t=%0t) observed=%0h expected=%0h", tag, sel, $time, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("pc_redirect", 32'(redir_w[sel]), 32'(e.redir));
      chk("pc_src",      32'(src_w[sel]),   32'(e.src));
      chk("pc_target",   tgt_w[sel],        e.tgt);
      chk("flush",       32'(flush_w[sel]), 32'(e.flush));
      chk("busy",        32'(busy_w[sel]),  32'(e.busy));
    end
  endtask

  task automatic set_tg(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    tgt = {t2, t1, t0};
  endtask

  // Drive one cycle of inputs; e is what the outputs must show after the edge.
  task automatic cyc(input logic s, input logic [2:0] r, input exp_t e);
    stall = s;
    req   = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    req   = '0;
    sb.push_back(E(1'b0, 2'd3, 32'h0, 2'b00, 1'b0));
    @(posedge clk);
    #1;
    check_out();
    rst = 1'b0;
  endtask

  initial begin
    // ---- SQUASH_CYCLES = 1 ----
    sel = 1;
    do_reset();
    cyc(0, 3'b000, E(0, 3, 32'h0,   2'b00, 0));
    set_tg(32'h10, 32'h100, 32'h30);
    cyc(0, 3'b010, E(1, 1, 32'h100, 2'b01, 1));
    cyc(0, 3'b000, E(0, 3, 32'h100, 2'b00, 0));
    set_tg(32'h10, 32'h20, 32'h30);
    cyc(0, 3'b111, E(1, 0, 32'h10,  2'b11, 1));
    cyc(0, 3'b111, E(0, 3, 32'h10,  2'b00, 0));   // dropped in window
    cyc(0, 3'b000, E(0, 3, 32'h10,  2'b00, 0));
    // stalled capture, replacement, ignored lower priority, then release
    cyc(1, 3'b100, E(0, 3, 32'h10,  2'b00, 1));
    set_tg(32'h44, 32'h20, 32'h30);
    cyc(1, 3'b001, E(0, 3, 32'h10,  2'b00, 1));
    cyc(1, 3'b010, E(0, 3, 32'h10,  2'b00, 1));
    cyc(1, 3'b000, E(0, 3, 32'h10,  2'b00, 1));
    cyc(0, 3'b000, E(1, 0, 32'h44,  2'b11, 1));
    cyc(0, 3'b000, E(0, 3, 32'h44,  2'b00, 0));
    // replacement applied in the same cycle stall drops
    set_tg(32'h10, 32'h20, 32'h30);
    cyc(1, 3'b100, E(0, 3, 32'h44,  2'b00, 1));
    cyc(0, 3'b010, E(1, 1, 32'h20,  2'b01, 1));
    cyc(0, 3'b000, E(0, 3, 32'h20,  2'b00, 0));
    // reset while pending discards the entry
    cyc(1, 3'b100, E(0, 3, 32'h20,  2'b00, 1));
    do_reset();
    cyc(0, 3'b000, E(0, 3, 32'h0,   2'b00, 0));
    cyc(0, 3'b000, E(0, 3, 32'h0,   2'b00, 0));

    // ---- SQUASH_CYCLES = 2 ----
    sel = 2;
    do_reset();
    set_tg(32'h10, 32'h20, 32'h30);
    cyc(0, 3'b001, E(1, 0, 32'h10,  2'b11, 1));
    cyc(0, 3'b001, E(0, 3, 32'h10,  2'b00, 1));
    cyc(0, 3'b001, E(0, 3, 32'h10,  2'b00, 0));
    cyc(0, 3'b001, E(1, 0, 32'h10,  2'b11, 1));
    // stall mid-window stretches it by one cycle
    cyc(0, 3'b001, E(0, 3, 32'h10,  2'b00, 1));
    cyc(1, 3'b001, E(0, 3, 32'h10,  2'b00, 1));
    cyc(0, 3'b001, E(0, 3, 32'h10,  2'b00, 0));
    cyc(0, 3'b001, E(1, 0, 32'h10,  2'b11, 1));
    cyc(0, 3'b000, E(0, 3, 32'h10,  2'b00, 1));
    cyc(0, 3'b000, E(0, 3, 32'h10,  2'b00, 0));

    // ---- SQUASH_CYCLES = 0 ----
    sel = 0;
    do_reset();
    set_tg(32'h10, 32'h20, 32'h30);
    cyc(0, 3'b001, E(1, 0, 32'h10,  2'b11, 0));
    cyc(0, 3'b100, E(1, 2, 32'h30,  2'b01, 0));
    cyc(0, 3'b010, E(1, 1, 32'h20,  2'b01, 0));
    cyc(0, 3'b000, E(0, 3, 32'h20,  2'b00, 0));
    cyc(1, 3'b100, E(0, 3, 32'h20,  2'b00, 1));
    cyc(0, 3'b000, E(1, 2, 32'h30,  2'b01, 0));
    cyc(0, 3'b000, E(0, 3, 32'h30,  2'b00, 0));

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Parametrised PC-redirect and pipeline-flush controller for the RISC-V pipeline. It arbitrates NUM_SRC fixed-priority redirect requests, such as branch-taken, JALR and JAL, and emits a registered one-cycle redirect with its target. It also emits a per-source flush mask over STAGES pipeline registers. Unlike the combinational control box it succeeds, it holds a redirect across front-end stalls and squashes wrong-path requests for a programmable window after each redirect.

## Interface
- XLEN, 32, PC/target width.
- NUM_SRC, 3, number of redirect sources; index 0 is highest priority (branch=0, JALR=1, JAL=2 by default).
- STAGES, 2, number of flushable pipeline registers; bit 0 = IF/ID, bit 1 = ID/EX.
- SRC_FLUSH_MASK, 6'b01_01_11, STAGES bits per source, with source 0 in the LSBs. Default: branch flushes IF/ID+ID/EX; JALR and JAL flush IF/ID only.
- SQUASH_CYCLES, 1, unstalled cycles after an issued redirect during which all requests are dropped; 0 is legal.
- clk  in  1  the block's single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  front-end stall; a redirect cannot issue while high.
- req  in  NUM_SRC  redirect request per source, level-sampled each cycle.
- req_target  in  NUM_SRC*XLEN  target per source; source i occupies bits [i*XLEN +: XLEN].
- pc_redirect  out  1  one-cycle pulse: PC must load pc_target.
- pc_target  out  XLEN  redirect target; valid when pc_redirect=1.
- pc_src  out  SRCW  winning source index, or NUM_SRC (the PC+4 code) when no redirect. SRCW = $clog2(NUM_SRC+1).
- flush  out  STAGES  one-cycle flush pulse per pipeline register, coincident with pc_redirect.
- busy  out  1  high in PENDING or SQUASH.

## Operation
- Reset values: pc_redirect=0, pc_target=0, pc_src=NUM_SRC, flush=0, busy=0. State is IDLE, pending cleared, squash counter 0.
- Arbitration: the winner is the lowest index i with req[i]=1. Its target is req_target slice i; its flush is SRC_FLUSH_MASK slice i.
- IDLE, req present and stall=0: issue the winner and go to SQUASH; if SQUASH_CYCLES=0, stay in IDLE.
- IDLE, req present and stall=1: capture the winner's index and target into the pending register and go to PENDING. Nothing issues.
- PENDING: a req with index < pending index replaces the pending index and target; reqs with index >= pending index are ignored.
  - When stall=0, issue the pending entry. If a higher-priority req arrives in the same cycle, the replacement is applied first and the replacement issues.
  - Then go to SQUASH (or IDLE when SQUASH_CYCLES=0).
- SQUASH: the counter is loaded with SQUASH_CYCLES at issue and decrements only on cycles with stall=0. All req are dropped. Return to IDLE when the counter reaches 0.
- Issue means the output registers load pc_redirect=1, pc_target, pc_src=winner and flush=mask on the next edge. On the following edge they return to pc_redirect=0, flush=0, pc_src=NUM_SRC; pc_target holds its last value.
- Reset mid-operation discards any pending redirect and any squash window.
- Illegal parameters (NUM_SRC<1, STAGES<1, SQUASH_CYCLES<0) fail elaboration.

## Timing
- An unstalled request sampled at edge N produces pc_redirect/flush high in cycle N+1 for exactly one cycle.
- When stall falls at edge M with an entry pending, outputs pulse in cycle M+1.
- The squash window covers the SQUASH_CYCLES unstalled cycles starting at N+1; requests are next evaluated after the window.
- With SQUASH_CYCLES=0, back-to-back redirects on consecutive cycles are legal.
- No combinational path from inputs to outputs.

## Structure
- Package redirect_pkg holds:
  - the state enum: IDLE, PENDING, SQUASH;
  - the SRCW and squash-counter-width helper functions;
  - the default SRC_FLUSH_MASK and source-index constants (SRC_BRANCH, SRC_JALR, SRC_JAL).
- Sub-module redirect_prio_enc: parametrised lowest-index priority encoder that outputs a valid bit and the index. It is instantiated once for fresh arbitration; the PENDING replacement uses a compare against the stored index.

## Test plan
- After reset: all outputs at reset values, pc_src=3. Then req=3'b010 with target 0x100 and stall=0 → next cycle pc_redirect=1, pc_src=1, pc_target=0x100, flush=2'b01. One cycle later all outputs return to idle.
- req=3'b111 (targets 0x10/0x20/0x30) → pc_src=0, pc_target=0x10, flush=2'b11.
- stall=1 with req=3'b100 (0x30) → no pulse, busy=1. Then req=3'b001 (0x10) while stalled, and stall drops 3 cycles later → single pulse, pc_src=0, target 0x10.
- SQUASH_CYCLES=2: redirect issued, then req=3'b001 held for the next 2 unstalled cycles → no pulse during the window; pulse once the window ends. Inserting a stall cycle mid-window extends it by one cycle.
- SQUASH_CYCLES=0: req pulses on consecutive cycles → pulses on consecutive cycles.
- reset asserted while PENDING → no pulse ever issues for the dropped entry; outputs at reset values next cycle.
